// File: rtl/vga_pkg.sv
// Shared definitions for the VGA compositor.
// - reg_addr_e : register map decoded from reg_addr.
// - CTRL_*     : bit positions inside the CTRL register.
// - DEF_*      : default 640x480 timing (pixels / lines).
package vga_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_KEY  = 2'd1,
    REG_BG   = 2'd2,
    REG_RSVD = 2'd3
  } reg_addr_e;

  localparam int CTRL_GLOBAL_EN = 0;
  localparam int CTRL_EN_LSB    = 4;
  localparam int CTRL_BLINK_LSB = 8;
  localparam int CTRL_IMM       = 31;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pix_stb      : one-clk pulse at the last clk of every pixel period
//   hcnt, vcnt   : current pixel/line position
//   active       : current position lies in the visible area
//   frame_start  : the strobe on which the counters wrap back to (0,0)
//   hsync, vsync : active-low syncs, delayed one pixel to line up with rgb
//   busy, vblank : active-area / vertical-blank flags, delayed one pixel
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_stb,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       active,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       busy,
  output logic       vblank
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = $clog2(PIX_DIV);

  logic [DIV_W-1:0] div;
  logic             h_last;
  logic             v_last;
  logic             in_hs;
  logic             in_vs;

  assign pix_stb     = (div == DIV_W'(PIX_DIV - 1));
  assign h_last      = (hcnt == 10'(H_TOTAL - 1));
  assign v_last      = (vcnt == 10'(V_TOTAL - 1));
  assign frame_start = pix_stb && h_last && v_last;
  assign active      = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign in_hs       = (hcnt >= 10'(HS_START)) && (hcnt < 10'(HS_END));
  assign in_vs       = (vcnt >= 10'(VS_START)) && (vcnt < 10'(VS_END));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and evaluation order inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      hcnt   <= '0;
      vcnt   <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      busy   <= 1'b0;
      vblank <= 1'b0;
    end else begin
      div <= pix_stb ? '0 : div + DIV_W'(1);
      if (pix_stb) begin
        hcnt <= h_last ? '0 : hcnt + 10'd1;
        if (h_last) vcnt <= v_last ? '0 : vcnt + 10'd1;
        // Flags describe the pixel now being sampled by the compositor, so
        // they leave on the same edge as its colour.
        hsync  <= !in_hs;
        vsync  <= !in_vs;
        busy   <= active;
        vblank <= (vcnt >= 10'(V_ACTIVE));
      end
    end
  end

endmodule

// File: rtl/vga_compositor.sv
// Multi-layer VGA compositor with double-buffered control registers.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   we_reg, reg_addr, data_in : register write port (CTRL/KEY/BG)
//   layer_color               : packed {R,G,B} per layer, layer i at slice i
//   column, row               : pixel requested from the layer sources
//   pix_stb                   : one-clk pulse per pixel
//   r, g, b                   : composited colour (one pixel latency)
//   hsync, vsync              : active-low syncs aligned with r/g/b
//   status                    : {frame_cnt, 13'b0, pending, vblank, busy}
module vga_compositor import vga_pkg::*; #(
  parameter int NUM_LAYERS   = 3,
  parameter int CW           = 4,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int PIX_DIV      = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_reg,
  input  logic [1:0]                 reg_addr,
  input  logic [31:0]                data_in,
  input  logic [NUM_LAYERS*3*CW-1:0] layer_color,
  output logic [9:0]                 column,
  output logic [8:0]                 row,
  output logic                       pix_stb,
  output logic [CW-1:0]              r,
  output logic [CW-1:0]              g,
  output logic [CW-1:0]              b,
  output logic                       hsync,
  output logic                       vsync,
  output logic [31:0]                status
);

  localparam int PW = 3 * CW;

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       active;
  logic       frame_start;
  logic       busy;
  logic       vblank;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV (PIX_DIV)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_stb    (pix_stb),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .active     (active),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .busy       (busy),
    .vblank     (vblank)
  );

  // Shadow (sh_) registers take writes; live (lv_) registers drive the output.
  logic                  sh_gen,   lv_gen;
  logic [NUM_LAYERS-1:0] sh_en,    lv_en;
  logic [NUM_LAYERS-1:0] sh_blink, lv_blink;
  logic [PW-1:0]         sh_key,   lv_key;
  logic [PW-1:0]         sh_bg,    lv_bg;
  logic                  pending;
  logic                  imm_q;
  logic [15:0]           frame_cnt;
  logic [15:0]           blink_cnt;
  logic                  blink_phase;
  logic [PW-1:0]         rgb_q;
  logic [PW-1:0]         pix_sel;
  logic                  wr_ctrl, wr_key, wr_bg, wr_any, apply;
  logic                  unused_bits;

  assign wr_ctrl = we_reg && (reg_addr == REG_CTRL);
  assign wr_key  = we_reg && (reg_addr == REG_KEY);
  assign wr_bg   = we_reg && (reg_addr == REG_BG);
  assign wr_any  = wr_ctrl || wr_key || wr_bg;
  // Frame-start apply and the clk after an immediate CTRL write share one path.
  assign apply   = frame_start || imm_q;

  // NOTE: every variable driven here gets a default before any condition,
  // otherwise a missed branch would infer a latch.
  always_comb begin
    pix_sel = lv_bg;
    // Ascending scan: a later (higher-index) winner overrides earlier ones.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (lv_en[i] && (layer_color[i*PW +: PW] != lv_key) &&
          (!lv_blink[i] || blink_phase))
        pix_sel = layer_color[i*PW +: PW];
    end
    if (!active || !lv_gen) pix_sel = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: the register file is a handful of flops, not a RAM, so all of it
    // is reset; a mid-frame reset therefore also discards half-written shadows.
    if (rst) begin
      sh_gen      <= 1'b0;
      sh_en       <= '0;
      sh_blink    <= '0;
      sh_key      <= '0;
      sh_bg       <= '0;
      lv_gen      <= 1'b0;
      lv_en       <= '0;
      lv_blink    <= '0;
      lv_key      <= '0;
      lv_bg       <= '0;
      pending     <= 1'b0;
      imm_q       <= 1'b0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      rgb_q       <= '0;
    end else begin
      // Live copies take the pre-edge shadow, so a write landing on the
      // apply clk stays shadowed for the next apply.
      if (apply) begin
        lv_gen   <= sh_gen;
        lv_en    <= sh_en;
        lv_blink <= sh_blink;
        lv_key   <= sh_key;
        lv_bg    <= sh_bg;
      end
      if (wr_ctrl) begin
        sh_gen   <= data_in[CTRL_GLOBAL_EN];
        sh_en    <= data_in[CTRL_EN_LSB +: NUM_LAYERS];
        sh_blink <= data_in[CTRL_BLINK_LSB +: NUM_LAYERS];
      end
      if (wr_key) sh_key <= data_in[PW-1:0];
      if (wr_bg)  sh_bg  <= data_in[PW-1:0];
      imm_q <= wr_ctrl && data_in[CTRL_IMM];

      if (wr_any)     pending <= 1'b1;
      else if (apply) pending <= 1'b0;

      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end

      if (pix_stb) rgb_q <= pix_sel;
    end
  end

  assign column = active ? hcnt : 10'd0;
  assign row    = active ? vcnt[8:0] : 9'd0;
  assign r      = rgb_q[3*CW-1 -: CW];
  assign g      = rgb_q[2*CW-1 -: CW];
  assign b      = rgb_q[CW-1:0];
  assign status = {frame_cnt, 13'b0, pending, vblank, busy};

  // Data bits beyond the CTRL fields and the top line-counter bit are don't-care.
  assign unused_bits = &{1'b0, data_in, vcnt[9]};

endmodule

// File: tb/tb_vga_compositor.sv
module tb_vga_compositor;

  localparam int NL = 3, CW = 4, PW = 12;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int PIX_DIV = 4, BLINK_FRAMES = 2;
  localparam int H_TOTAL = 16, V_TOTAL = 10;
  localparam int LINE_CLKS = H_TOTAL * PIX_DIV;    // 64
  localparam int FRAME_CLKS = LINE_CLKS * V_TOTAL; // 640

  logic              clk = 1'b0;
  logic              rst;
  logic              we_reg;
  logic [1:0]        reg_addr;
  logic [31:0]       data_in;
  logic [NL*PW-1:0]  layer_color;
  logic [9:0]        column;
  logic [8:0]        row;
  logic              pix_stb;
  logic [CW-1:0]     r, g, b;
  logic              hsync, vsync;
  logic [31:0]       status;
  logic [PW-1:0]     rgb;

  int n_cmp = 0;
  int n_err = 0;

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  vga_compositor #(
    .NUM_LAYERS(NL), .CW(CW),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .we_reg(we_reg), .reg_addr(reg_addr),
    .data_in(data_in), .layer_color(layer_color), .column(column), .row(row),
    .pix_stb(pix_stb), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .status(status)
  );

  // ---------------- helpers (stimulus / synchronisation only) -------------
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); we_reg = 1'b1; reg_addr = a; data_in = d;
    @(negedge clk); we_reg = 1'b0;
  endtask

  // Returns #1 after the strobe edge that samples pixel (h,v) into rgb.
  task automatic goto_pixel(input int h, input int v);
    int n = 0;
    @(negedge clk);
    while (!(pix_stb && column == h && row == v) && n < 2*FRAME_CLKS) begin
      @(negedge clk); n++;
    end
    if (n >= 2*FRAME_CLKS) begin
      n_cmp++; n_err++;
      $display("FAIL goto_pixel_timeout: pixel (%0d,%0d) not reached in %0d clks", h, v, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic next_strobe();
    int n = 0;
    @(negedge clk);
    while (!pix_stb && n < 4*PIX_DIV) begin @(negedge clk); n++; end
    if (n >= 4*PIX_DIV) begin
      n_cmp++; n_err++;
      $display("FAIL strobe_timeout: no pix_stb in %0d clks", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    logic [15:0] fc0;
    fc0 = status[31:16];
    @(negedge clk);
    while (status[31:16] == fc0 && n < 2*FRAME_CLKS) begin @(negedge clk); n++; end
    if (n >= 2*FRAME_CLKS) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout: frame_cnt stuck at %0d", fc0);
    end
  endtask

  // Counts clks until the chosen sync (0=hsync, 1=vsync) reaches lvl.
  task automatic count_until(input int sel, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((((sel == 0) ? hsync : vsync) !== lvl) && n < 4*FRAME_CLKS);
    if (n >= 4*FRAME_CLKS) begin
      n_cmp++; n_err++;
      $display("FAIL sync_timeout: sel %0d never reached %b", sel, lvl);
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    int n;
    rst = 1'b1; we_reg = 1'b0; reg_addr = 2'd0; data_in = '0; layer_color = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_cmp++; if (pix_stb !== 1'b0) begin n_err++; $display("FAIL reset_pix_stb: got %b want 0", pix_stb); end
    n_cmp++; if (status !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", status); end
    n_cmp++; if (column !== 10'd0 || row !== 9'd0) begin
      n_err++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", column, row);
    end
    rst = 1'b0;
    // The first strobe is consumed on the PIX_DIV-th edge: column steps to 1 there.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (column !== 10'd1 && n < 50);
    n_cmp++; if (n != PIX_DIV) begin n_err++; $display("FAIL first_strobe: column advanced after %0d clks want %0d", n, PIX_DIV); end
  endtask

  task automatic test_sync_timing();
    int n, lo, hi, lines;
    logic prev_hs, prev_vs;
    count_until(0, 1'b0, n);
    count_until(0, 1'b1, lo);
    count_until(0, 1'b0, hi);
    n_cmp++; if (lo != H_SYNC*PIX_DIV) begin n_err++; $display("FAIL hsync_low: got %0d want %0d", lo, H_SYNC*PIX_DIV); end
    n_cmp++; if (lo + hi != LINE_CLKS) begin n_err++; $display("FAIL hsync_period: got %0d want %0d", lo+hi, LINE_CLKS); end
    count_until(1, 1'b0, n);
    count_until(1, 1'b1, lo);
    count_until(1, 1'b0, hi);
    n_cmp++; if (lo != V_SYNC*LINE_CLKS) begin n_err++; $display("FAIL vsync_low: got %0d want %0d", lo, V_SYNC*LINE_CLKS); end
    n_cmp++; if (lo + hi != FRAME_CLKS) begin n_err++; $display("FAIL vsync_period: got %0d want %0d", lo+hi, FRAME_CLKS); end
    // Now at a vsync fall: count hsync falls until the next vsync fall.
    lines = 0; n = 0; prev_hs = hsync; prev_vs = vsync;
    do begin
      prev_hs = hsync; prev_vs = vsync;
      @(negedge clk); n++;
      if (prev_hs && !hsync) lines++;
    end while (!(prev_vs && !vsync) && n < 2*FRAME_CLKS);
    n_cmp++; if (lines != V_TOTAL) begin n_err++; $display("FAIL lines_per_frame: got %0d want %0d", lines, V_TOTAL); end
  endtask

  task automatic test_layers();
    write_reg(2'd1, 32'h0);
    write_reg(2'd0, 32'h8000_0071);
    layer_color = {12'hF00, 12'h0F0, 12'h00F};
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL layer2_wins: got %h want F00", rgb); end
    layer_color = {12'h000, 12'h0F0, 12'h00F};
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL layer2_keyed: got %h want 0F0", rgb); end
    layer_color = {12'h000, 12'h000, 12'h00F};
    goto_pixel(4, 3);
    n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL layer0_only: got %h want 00F", rgb); end
    // Non-zero key: layers 2 and 1 both match it, layer 0 shows.
    write_reg(2'd1, 32'h0F0);
    write_reg(2'd0, 32'h8000_0071);
    layer_color = {12'h0F0, 12'h0F0, 12'h00F};
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL key_0f0: got %h want 00F", rgb); end
    write_reg(2'd1, 32'h0);
    write_reg(2'd0, 32'h8000_0071);
  endtask

  task automatic test_bg();
    write_reg(2'd2, 32'hABC);
    write_reg(2'd0, 32'h8000_0001);
    layer_color = {12'hF00, 12'h0F0, 12'h00F};
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'hABC) begin n_err++; $display("FAIL bg_active: got %h want ABC", rgb); end
    goto_pixel(7, 2);
    next_strobe();  // hcnt = H_ACTIVE: horizontal blanking
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL bg_blank: got %h want 000", rgb); end
    write_reg(2'd0, 32'h8000_0070);
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL global_off: got %h want 000", rgb); end
  endtask

  task automatic test_shadow();
    write_reg(2'd0, 32'h8000_0071);
    layer_color = {12'hF00, 12'h0F0, 12'h00F};
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL shadow_before: got %h want F00", rgb); end
    write_reg(2'd0, 32'h0000_0031);
    n_cmp++; if (status[2] !== 1'b1) begin n_err++; $display("FAIL shadow_pending_set: got %b want 1", status[2]); end
    goto_pixel(6, 2);
    n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL shadow_held: got %h want F00", rgb); end
    wait_frame();
    n_cmp++; if (status[2] !== 1'b0) begin n_err++; $display("FAIL shadow_pending_clr: got %b want 0", status[2]); end
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL shadow_applied: got %h want 0F0", rgb); end
    write_reg(2'd0, 32'h8000_0011);
    n_cmp++; if (status[2] !== 1'b1) begin n_err++; $display("FAIL imm_pending_set: got %b want 1", status[2]); end
    @(posedge clk); #1;
    n_cmp++; if (status[2] !== 1'b0) begin n_err++; $display("FAIL imm_pending_clr: got %b want 0", status[2]); end
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL imm_applied: got %h want 00F", rgb); end
  endtask

  task automatic test_back_to_back();
    goto_pixel(1, 1);
    // KEY write lands on the clk that applies the immediate CTRL write.
    @(negedge clk); we_reg = 1'b1; reg_addr = 2'd0; data_in = 32'h8000_0071;
    @(negedge clk); reg_addr = 2'd1; data_in = 32'hF00;
    @(negedge clk); we_reg = 1'b0;
    n_cmp++; if (status[2] !== 1'b1) begin n_err++; $display("FAIL b2b_pending: got %b want 1", status[2]); end
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL b2b_key_shadowed: got %h want F00", rgb); end
    wait_frame();
    n_cmp++; if (status[2] !== 1'b0) begin n_err++; $display("FAIL b2b_pending_clr: got %b want 0", status[2]); end
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL b2b_key_live: got %h want 0F0", rgb); end
  endtask

  task automatic test_blink();
    logic [PW-1:0] exp;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    layer_color = {12'h000, 12'h000, 12'h00F};
    write_reg(2'd2, 32'h123);
    write_reg(2'd0, 32'h8000_0111);
    for (int f = 0; f < 5; f++) begin
      goto_pixel(3, 2);
      exp = (((f / BLINK_FRAMES) % 2) == 1) ? 12'h00F : 12'h123;
      n_cmp++; if (status[31:16] !== 16'(f)) begin n_err++; $display("FAIL blink_frame_cnt[%0d]: got %0d want %0d", f, status[31:16], f); end
      n_cmp++; if (rgb !== exp) begin n_err++; $display("FAIL blink_rgb[%0d]: got %h want %h", f, rgb, exp); end
    end
  endtask

  task automatic test_reset_midframe();
    goto_pixel(2, 4);
    write_reg(2'd0, 32'h0000_0071);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_err++; $display("FAIL mid_rst_sync: got %b%b want 11", hsync, vsync); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL mid_rst_rgb: got %h want 000", rgb); end
    n_cmp++; if (status !== 32'h0) begin n_err++; $display("FAIL mid_rst_status: got %h want 0", status); end
    n_cmp++; if (column !== 10'd0 || row !== 9'd0) begin n_err++; $display("FAIL mid_rst_pos: got (%0d,%0d) want (0,0)", column, row); end
    @(negedge clk); rst = 1'b0;
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL mid_rst_live_clr: got %h want 000", rgb); end
    n_cmp++; if (status[31:16] !== 16'd0) begin n_err++; $display("FAIL mid_rst_fcnt: got %0d want 0", status[31:16]); end
    wait_frame();
    goto_pixel(3, 2);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL mid_rst_no_apply: got %h want 000", rgb); end
    n_cmp++; if (status[31:16] !== 16'd1) begin n_err++; $display("FAIL mid_rst_fcnt1: got %0d want 1", status[31:16]); end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_layers();
    test_bg();
    test_shadow();
    test_back_to_back();
    test_blink();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
